// File: rtl/font_ram_writer_if.sv
// Byte-stream and font-RAM write-port bundle for font_ram_writer.
// slave  : the writer itself (consumes the stream, drives the RAM write port).
// master : the surroundings (UART byte source and the font RAM write port).
interface font_ram_writer_if;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 12;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  wr_addr,
    input  wr_data,
    input  wr_en
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output wr_addr,
    output wr_data,
    output wr_en
  );

endinterface

// File: rtl/font_ram_writer.sv
// font_ram_writer: loads glyph bitmaps into the 4K x 8 font RAM from a byte
// stream. Stream format: one code byte, then 16 row bytes (top row first);
// row r of code c is written at address {c, r}.
// Optional macro FONT_WRITER_TIMEOUT_EN: abandon a partial glyph after
// TIMEOUT_CYCLES idle cycles and pulse 'aborted'. Without it 'aborted' is 0.
module font_ram_writer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  font_ram_writer_if.slave bus,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned ADDR_W = DATA_W + ROW_W;
  localparam int unsigned IDLE_W = 24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROWS = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   code_q, code_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  logic                in_ready_c;
  logic                xfer_c;
  logic                timeout_hit_c;

  // Ready is decoded from state only; held low while reset is asserted.
  assign in_ready_c = !reset && (state_q != S_DONE);
  assign xfer_c     = bus.in_valid && in_ready_c;

`ifdef FONT_WRITER_TIMEOUT_EN
  logic [IDLE_W-1:0] idle_q, idle_d;

  // Idle counter: counts ROWS cycles without a transfer, zero elsewhere.
  always_comb begin
    idle_d = idle_q;
    if (xfer_c || (state_q != S_ROWS)) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  // Terminal count with no transfer this cycle; a coinciding transfer wins.
  assign timeout_hit_c = (state_q == S_ROWS) && !xfer_c &&
                         (idle_q == (TIMEOUT_CYCLES - IDLE_W'(1)));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit_c  = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      row_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      row_q     <= row_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer_c) begin
          state_d = S_ROWS;
        end
      end
      S_ROWS: begin
        if (xfer_c && (row_q == ROW_W'(15))) begin
          state_d = S_DONE;
        end else if (timeout_hit_c) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    code_d    = code_q;
    row_d     = row_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer_c) begin
          code_d = bus.in_data;
          row_d  = '0;
        end
      end
      S_ROWS: begin
        if (xfer_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {code_q, row_q};
          wr_data_d = bus.in_data;
          // Row 15 leaves for DONE, so the counter never wraps.
          if (row_q != ROW_W'(15)) begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: begin
      end
    endcase
    busy_d    = (state_d == S_ROWS);
    done_d    = (state_d == S_DONE);
    aborted_d = timeout_hit_c;
  end

  // Strobes are masked during reset so a byte accepted just before reset
  // never reaches the RAM in the reset cycle.
  assign bus.in_ready = in_ready_c;
  assign bus.wr_en    = wr_en_q && !reset;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_q && !reset;
  assign done         = done_q && !reset;
  assign aborted      = aborted_q && !reset;

endmodule

// File: tb/tb_font_ram_writer.sv
// Directed bench for font_ram_writer (TIMEOUT_CYCLES=16 so the optional
// timeout scenarios stay short when FONT_WRITER_TIMEOUT_EN is defined).
module tb_font_ram_writer;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic done;
  logic aborted;

  int total = 0;
  int bad   = 0;

  logic [7:0] glyph_a [16] = '{8'h00, 8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66,
                               8'h66, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F};
  int gaps [16] = '{3, 0, 5, 1, 2, 0, 4, 0, 0, 5, 1, 3, 0, 2, 0, 1};

  always #5 clk = ~clk;

  font_ram_writer_if bus ();

  font_ram_writer #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  function automatic logic [7:0] rowval(input logic [7:0] c, input int k);
    return c ^ 8'((k * 37) + 1);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input logic we, input logic bz,
                        input logic dn, input logic rdy, input logic ab);
    cmp({tag, ".wr_en"},    32'(bus.wr_en),    32'(we));
    cmp({tag, ".busy"},     32'(busy),         32'(bz));
    cmp({tag, ".done"},     32'(done),         32'(dn));
    cmp({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
    cmp({tag, ".aborted"},  32'(aborted),      32'(ab));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    step();
  endtask

  // Idle cycles in ROWS (or IDLE when bz=0): no write expected.
  task automatic idle_chk(input string tag, input int n, input logic bz);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      status($sformatf("%s.idle%0d", tag, i), 1'b0, bz, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic push_row(input logic [7:0] c, input int k, input logic [7:0] d);
    string tag;
    tag = $sformatf("g%02h.r%0d", c, k);
    push(d);
    cmp({tag, ".addr"}, 32'(bus.wr_addr), 32'({c, 4'(k)}));
    cmp({tag, ".data"}, 32'(bus.wr_data), 32'(d));
    if (k == 15) status(tag, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    else         status(tag, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic load(input logic [7:0] c, input bit use_tab, input bit use_gaps);
    push(c);
    status($sformatf("g%02h.code", c), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (use_gaps) idle_chk($sformatf("g%02h.gap%0d", c, k), gaps[k], 1'b1);
      push_row(c, k, use_tab ? glyph_a[k] : rowval(c, k));
    end
  endtask

  task automatic post(input string tag);
    bus.in_valid = 1'b0;
    step();
    status(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) step();
    status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("reset.addr", 32'(bus.wr_addr), 32'(0));
    cmp("reset.data", 32'(bus.wr_data), 32'(0));
    reset = 1'b0;
    #1;
    status("reset_rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Glyph 0x41, valid held for 17 cycles.
    load(8'h41, 1'b1, 1'b0);
    post("g41.post");

    // Glyph 0xFF with idle gaps between bytes.
    load(8'hFF, 1'b0, 1'b1);
    post("gff.post");

    // Two glyphs back to back; next code held through DONE.
    load(8'h00, 1'b0, 1'b0);
    bus.in_data = 8'h01;
    step();
    status("done_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'h01, 1'b0, 1'b0);
    post("g01.post");

    // Reset after row 7 of glyph 0x30.
    push(8'h30);
    status("g30.code", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) push_row(8'h30, k, rowval(8'h30, k));
    bus.in_data = rowval(8'h30, 8);
    reset = 1'b1;
    #1;
    status("rst_cycle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    status("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("rst_after.addr", 32'(bus.wr_addr), 32'(0));
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    status("rst_release", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'h31, 1'b0, 1'b0);
    post("g31.post");

`ifdef FONT_WRITER_TIMEOUT_EN
    // Timeout: 3 rows then silence; abort 16 cycles after the last transfer.
    push(8'h20);
    status("g20.code", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) push_row(8'h20, k, rowval(8'h20, k));
    idle_chk("to20", 15, 1'b1);
    step();
    status("to20.abort", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    status("to20.after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'h21, 1'b0, 1'b0);
    post("g21.post");

    // Row byte on the terminal-count cycle wins and restarts the counter.
    push(8'h22);
    status("g22.code", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) push_row(8'h22, k, rowval(8'h22, k));
    idle_chk("tc22a", 15, 1'b1);
    push_row(8'h22, 3, rowval(8'h22, 3));
    idle_chk("tc22b", 15, 1'b1);
    step();
    status("tc22.abort", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    status("tc22.after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'h23, 1'b0, 1'b0);
    post("g23.post");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
